seq_multiplier: RTL

- Parametrised sequential shift-add multiplier: MW-bit multiplicand by PW-bit multiplier, full-width product.
- Successor to the combinational 3x2 array multiplier. It trades latency (PW cycles) for area: one shared adder instead of an adder array.
- Start/busy/done handshake. Sits beside the adder and multiplier blocks in the arithmetic library and is driven by a simple controller or testbench.

---
 rtl/seq_multiplier.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: MW-bit multiplicand x PW-bit multiplier, one bit per clock.
// Define MULT_SIGNED_EN to add the tc input for two's-complement operands.
module seq_multiplier #(
   parameter int MW = 8,
   parameter int PW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MW-1:0]     m,
   input  logic [PW-1:0]     p,
`ifdef MULT_SIGNED_EN
   input  logic              tc,
`endif
   output logic              busy,
   output logic              done,
   output logic [MW+PW-1:0]  s
);

   localparam int CW = $clog2(PW + 1);
   localparam int AW = MW + PW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [MW-1:0]     mcand_q, mcand_d;
   // Upper MW+1 bits are the partial sum; lower PW bits hold the remaining multiplier bits.
   logic [AW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [MW+PW-1:0]  s_q, s_d;
   logic              signed_s;
   logic              last_s;
   logic [MW:0]       ext_m_s;
   logic [MW:0]       addend_s;
   logic [MW:0]       sum_s;
   logic [AW-1:0]     step_s;

`ifdef MULT_SIGNED_EN
   logic              tc_q, tc_d;
   assign signed_s = tc_q;
`else
   assign signed_s = 1'b0;
`endif

   // One shift-add iteration of the datapath
   always_comb begin
      ext_m_s = signed_s ? {mcand_q[MW-1], mcand_q} : {1'b0, mcand_q};
      last_s  = (cnt_q == CW'(PW - 1));
      if (acc_q[0]) begin
         // In signed mode the multiplier MSB carries negative weight.
         addend_s = (signed_s && last_s) ? (~ext_m_s + (MW+1)'(1)) : ext_m_s;
      end else begin
         addend_s = '0;
      end
      sum_s  = acc_q[AW-1:PW] + addend_s;
      step_s = {signed_s & sum_s[MW], sum_s, acc_q[PW-1:1]};
   end

   // Control FSM and next-state selection
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      s_d     = s_q;
`ifdef MULT_SIGNED_EN
      tc_d    = tc_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mcand_d = m;
               acc_d   = {{(MW+1){1'b0}}, p};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
`ifdef MULT_SIGNED_EN
               tc_d    = tc;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = step_s;
            cnt_d = cnt_q + CW'(1);
            if (last_s) begin
               s_d     = step_s[MW+PW-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
`ifdef MULT_SIGNED_EN
         tc_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         s_q     <= s_d;
`ifdef MULT_SIGNED_EN
         tc_q    <= tc_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;

endmodule
